// File: rtl/bus_arbiter_pkg.sv
// Shared types for the Amiga bus arbiter: FSM state encoding, the registered
// output bundle, and the IS_BM bit position in the Pi status register.
package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    OWN_IDLE   = 3'd0,
    OWN_BUSY   = 3'd1,
    GRANT_PEND = 3'd2,
    GRANTED    = 3'd3,
    EXT_OWNED  = 3'd4,
    REACQUIRE  = 3'd5
  } arb_state_e;

  localparam int unsigned PI_REG_STATUS_IS_BM = 3;

  typedef struct packed {
    logic xfer_go;
    logic bg_drive;
    logic ctrl_drive;
    logic is_bm;
  } arb_out_t;

  localparam arb_out_t ARB_OUT_RESET = '{xfer_go: 1'b0, bg_drive: 1'b0,
                                         ctrl_drive: 1'b1, is_bm: 1'b1};

  // Output values that belong to a state; XFER_GO in OWN_IDLE mirrors the request.
  function automatic arb_out_t decode_outputs(arb_state_e s, logic xfer_req);
    arb_out_t o;
    o = ARB_OUT_RESET;
    case (s)
      OWN_IDLE:   o.xfer_go = xfer_req;
      OWN_BUSY:   o.xfer_go = 1'b1;
      GRANT_PEND: o.xfer_go = 1'b0;
      GRANTED: begin
        o.bg_drive   = 1'b1;
        o.ctrl_drive = 1'b0;
        o.is_bm      = 1'b0;
      end
      EXT_OWNED, REACQUIRE: begin
        o.ctrl_drive = 1'b0;
        o.is_bm      = 1'b0;
      end
      default: o = ARB_OUT_RESET;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for asynchronous active-low bus signals;
// resets to all ones so every input reads as negated.
module sync_ff #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  // NOTE: every stage is reset, not just the output, so no stale low level can ripple out after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '1;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates 68000 bus mastership between the Pi transfer engine and external
// Amiga bus masters (BR/BG/BGACK handshake), with a grant-withdrawal timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int REARB_MC    = 4
) (
  input  logic       SYSCLK,
  input  logic       nRST,
  input  logic       MCCLK_FALLING,
  input  logic       nBR_IN,
  input  logic       nBGACK_IN,
  input  logic       nAS_IN,
  input  logic       XFER_REQ,
  input  logic       XFER_BUSY,
  output logic       XFER_GO,
  output logic       BG_DRIVE,
  output logic       CTRL_DRIVE,
  output logic       IS_BM,
  output logic [2:0] ARB_STATE
);

  localparam int CNT_W = $clog2(REARB_MC + 1);
  localparam logic [CNT_W-1:0] REARB_LAST = CNT_W'(REARB_MC - 1);
  localparam logic [CNT_W-1:0] REARB_MAX  = CNT_W'(REARB_MC);

  logic [2:0]       sync_q;
  logic             br, bgack, as_active;
  arb_state_e       state, next_state;
  logic [CNT_W-1:0] rearb_cnt;
  arb_out_t         outs, outs_next;

  sync_ff #(.DEPTH(SYNC_STAGES), .WIDTH(3)) u_sync (
    .clk   (SYSCLK),
    .rst_n (nRST),
    .d     ({nBR_IN, nBGACK_IN, nAS_IN}),
    .q     (sync_q)
  );

  assign br        = ~sync_q[2];
  assign bgack     = ~sync_q[1];
  assign as_active = ~sync_q[0];

  // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SYSCLK or negedge nRST) begin
    if (!nRST) state <= OWN_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets its default first so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      // A transfer that has already started wins over BR; BR wins over a new request.
      OWN_IDLE:   if (XFER_BUSY) next_state = OWN_BUSY;
                  else if (br)   next_state = GRANT_PEND;
      OWN_BUSY:   if (!XFER_BUSY) next_state = br ? GRANT_PEND : OWN_IDLE;
      GRANT_PEND: if (MCCLK_FALLING && !as_active) next_state = GRANTED;
      GRANTED: begin
        if (bgack) next_state = EXT_OWNED;
        else if (MCCLK_FALLING && !br && rearb_cnt >= REARB_LAST) next_state = OWN_IDLE;
      end
      EXT_OWNED:  if (!bgack) next_state = REACQUIRE;
      REACQUIRE:  if (MCCLK_FALLING && !bgack && !as_active)
                    next_state = br ? GRANTED : OWN_IDLE;
      default:    next_state = OWN_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge nRST) begin
    if (!nRST) begin
      rearb_cnt <= '0;
    end else if (next_state != state || br || bgack) begin
      rearb_cnt <= '0;
    end else if (state == GRANTED && MCCLK_FALLING && rearb_cnt != REARB_MAX) begin
      rearb_cnt <= rearb_cnt + CNT_W'(1);
    end
  end

  // Outputs are decoded from next_state and registered, so they change together with ARB_STATE.
  always_comb outs_next = decode_outputs(next_state, XFER_REQ);

  always_ff @(posedge SYSCLK or negedge nRST) begin
    if (!nRST) outs <= ARB_OUT_RESET;
    else       outs <= outs_next;
  end

  assign XFER_GO    = outs.xfer_go;
  assign BG_DRIVE   = outs.bg_drive;
  assign CTRL_DRIVE = outs.ctrl_drive;
  assign IS_BM      = outs.is_bm;
  assign ARB_STATE  = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: handshake sequences with hand-computed
// state and output values, sampled on the falling SYSCLK edge.
module tb_bus_arbiter;

  logic       SYSCLK = 1'b0;
  logic       nRST, MCCLK_FALLING, nBR_IN, nBGACK_IN, nAS_IN, XFER_REQ, XFER_BUSY;
  logic       XFER_GO, BG_DRIVE, CTRL_DRIVE, IS_BM;
  logic [2:0] ARB_STATE;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_BUSY = 3'd1, S_PEND = 3'd2,
                         S_GRANTED = 3'd3, S_EXT = 3'd4, S_REACQ = 3'd5;

  bus_arbiter #(.SYNC_STAGES(2), .REARB_MC(4)) dut (
    .SYSCLK        (SYSCLK),
    .nRST          (nRST),
    .MCCLK_FALLING (MCCLK_FALLING),
    .nBR_IN        (nBR_IN),
    .nBGACK_IN     (nBGACK_IN),
    .nAS_IN        (nAS_IN),
    .XFER_REQ      (XFER_REQ),
    .XFER_BUSY     (XFER_BUSY),
    .XFER_GO       (XFER_GO),
    .BG_DRIVE      (BG_DRIVE),
    .CTRL_DRIVE    (CTRL_DRIVE),
    .IS_BM         (IS_BM),
    .ARB_STATE     (ARB_STATE)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic go,
                            input logic bg, input logic ctrl, input logic bm);
    check({tag, ".state"}, 32'(ARB_STATE), 32'(st));
    check({tag, ".xfer_go"}, 32'(XFER_GO), 32'(go));
    check({tag, ".bg_drive"}, 32'(BG_DRIVE), 32'(bg));
    check({tag, ".ctrl_drive"}, 32'(CTRL_DRIVE), 32'(ctrl));
    check({tag, ".is_bm"}, 32'(IS_BM), 32'(bm));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  // One MC falling-edge pulse lasting exactly one SYSCLK.
  task automatic mc_fall();
    MCCLK_FALLING = 1'b1;
    @(negedge SYSCLK);
    MCCLK_FALLING = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; MCCLK_FALLING = 1'b0; nBR_IN = 1'b1; nBGACK_IN = 1'b1;
    nAS_IN = 1'b1; XFER_REQ = 1'b0; XFER_BUSY = 1'b0;
    tick(2);
    check_outs("reset", S_IDLE, 0, 0, 1, 1);
    nRST = 1'b1;
    tick(2);
    check_outs("idle_no_req", S_IDLE, 0, 0, 1, 1);

    // Idle bus, transfer request granted on the next cycle.
    XFER_REQ = 1'b1;
    tick(1);
    check_outs("xfer_go", S_IDLE, 1, 0, 1, 1);
    XFER_BUSY = 1'b1;
    tick(1);
    check_outs("own_busy", S_BUSY, 1, 0, 1, 1);
    XFER_REQ = 1'b0;

    // BR during a transfer must wait for the transfer to finish and AS to negate.
    nBR_IN = 1'b0; nAS_IN = 1'b0;
    tick(4);
    mc_fall();
    check_outs("br_during_busy", S_BUSY, 1, 0, 1, 1);
    XFER_BUSY = 1'b0;
    tick(1);
    check_outs("busy_done_pend", S_PEND, 0, 0, 1, 1);
    mc_fall();
    check_outs("pend_as_low", S_PEND, 0, 0, 1, 1);
    nAS_IN = 1'b1;
    tick(3);
    check_outs("pend_no_mc", S_PEND, 0, 0, 1, 1);
    mc_fall();
    check_outs("granted", S_GRANTED, 0, 1, 0, 0);

    // External master takes the bus, then hands it back.
    nBGACK_IN = 1'b0; nBR_IN = 1'b1;
    tick(3);
    check_outs("ext_owned", S_EXT, 0, 0, 0, 0);
    nBGACK_IN = 1'b1;
    tick(3);
    check_outs("reacquire", S_REACQ, 0, 0, 0, 0);
    mc_fall();
    check_outs("reacq_idle", S_IDLE, 0, 0, 1, 1);

    // Grant withdrawal after 4 MC edges with BR negated; a BR blip restarts the count.
    nBR_IN = 1'b0;
    tick(3);
    check_outs("pend2", S_PEND, 0, 0, 1, 1);
    mc_fall();
    check_outs("granted2", S_GRANTED, 0, 1, 0, 0);
    nBR_IN = 1'b1;
    tick(3);
    repeat (2) mc_fall();
    nBR_IN = 1'b0;
    tick(3);
    nBR_IN = 1'b1;
    tick(3);
    repeat (3) mc_fall();
    check_outs("withdraw_3rd", S_GRANTED, 0, 1, 0, 0);
    mc_fall();
    check_outs("withdraw_4th", S_IDLE, 0, 0, 1, 1);

    // BR still asserted at reacquire goes straight back to GRANTED, but only once AS negates.
    nBR_IN = 1'b0;
    tick(3);
    mc_fall();
    nBGACK_IN = 1'b0;
    tick(3);
    check_outs("ext_owned2", S_EXT, 0, 0, 0, 0);
    nAS_IN = 1'b0; nBGACK_IN = 1'b1;
    tick(3);
    mc_fall();
    check_outs("reacq_as_low", S_REACQ, 0, 0, 0, 0);
    nAS_IN = 1'b1;
    tick(3);
    mc_fall();
    check_outs("reacq_regrant", S_GRANTED, 0, 1, 0, 0);

    // Reset while the external master owns the bus.
    nBGACK_IN = 1'b0;
    tick(3);
    check_outs("ext_owned3", S_EXT, 0, 0, 0, 0);
    nRST = 1'b0;
    #1;
    check_outs("async_reset", S_IDLE, 0, 0, 1, 1);
    nBGACK_IN = 1'b1;
    tick(1);
    nRST = 1'b1;
    tick(2);
    check_outs("post_reset_sync", S_IDLE, 0, 0, 1, 1);
    tick(1);
    check_outs("post_reset_pend", S_PEND, 0, 0, 1, 1);

    // Drain back to idle through the withdrawal path.
    nBR_IN = 1'b1;
    tick(3);
    mc_fall();
    repeat (4) mc_fall();
    check_outs("drain_idle", S_IDLE, 0, 0, 1, 1);

    // BR and XFER_REQ reach the FSM in the same cycle: BR wins.
    nBR_IN = 1'b0;
    tick(2);
    XFER_REQ = 1'b1;
    tick(1);
    check_outs("br_vs_req", S_PEND, 0, 0, 1, 1);
    tick(2);
    check("br_vs_req_hold.xfer_go", 32'(XFER_GO), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
